// File: rtl/semaforo_pkg.sv
// Shared definitions for the semaforo traffic-light controller family.
// Lamp encodings (one-hot), request FSM state codes and small helpers
// used by the pedestrian request front end.
package semaforo_pkg;

    // Lamp encodings for light A, one-hot: [2]=VERDE [1]=AMARELO [0]=VERMELHO
    localparam logic [2:0] VERDE    = 3'b100;
    localparam logic [2:0] AMARELO  = 3'b010;
    localparam logic [2:0] VERMELHO = 3'b001;

    // Request FSM state codes
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] PENDING  = 2'd1;
    localparam logic [1:0] COOLDOWN = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE     = IDLE,
        ST_PENDING  = PENDING,
        ST_COOLDOWN = COOLDOWN
    } req_state_e;

    // True when exactly one lamp bit is set
    function automatic logic is_onehot3(input logic [2:0] v);
        return (v == VERDE) || (v == AMARELO) || (v == VERMELHO);
    endfunction

    // 8-bit increment that sticks at 255
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/debounce_sync.sv
// Purpose: 2-FF synchroniser, counter debouncer and registered rising-edge detect for a raw button.
// Latency: din high sampled at edge k -> level high after edge k+DEB_CYCLES+1, rise high after edge k+DEB_CYCLES+2.
// Backpressure: none; free-running conditioner, rise is a 1-cycle strobe with no handshake.
// Ports: clk, rst (sync, active-low), din (async raw level), level (debounced level), rise (1-cycle press strobe).
module debounce_sync
    import semaforo_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise
);

    // Counter value at which the next mismatching cycle flips the level
    localparam logic [7:0] DEB_LAST = 8'(DEB_CYCLES - 1);

    logic       sync1_q;
    logic       sync2_q;
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;
    logic       level_q;
    logic       level_d;
    logic       level_prev_q;
    logic       rise_q;

    // Count consecutive cycles where the synchronised input disagrees with
    // the debounced level; any agreeing cycle restarts the count.
    always_comb begin
        cnt_d   = 8'd0;
        level_d = level_q;
        if (sync2_q != level_q) begin
            if (cnt_q == DEB_LAST) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            cnt_q        <= 8'd0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            rise_q       <= 1'b0;
        end else begin
            sync1_q      <= din;
            sync2_q      <= sync1_q;
            cnt_q        <= cnt_d;
            level_q      <= level_d;
            level_prev_q <= level_q;
            // Edge is taken from the registered level so it can never glitch
            rise_q       <= level_q & ~level_prev_q;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;

endmodule

// File: rtl/pedestrian_request_ctrl.sv
// Purpose: pedestrian push-button front end for semaforo: debounce, request FSM, service/timeout handling.
// Latency: clean bt_raw high sampled at edge k -> bt pulse in the cycle after edge k+DEB_CYCLES+3.
// Backpressure: none; presses arriving while a request is pending or cooling down are dropped.
// Ports: clk, rst (sync, active-low), bt_raw (raw button), a_state (light A one-hot),
//        bt (1-cycle request pulse), req_pending, press_cnt (saturating), err_state (bad a_state flag).
module pedestrian_request_ctrl
    import semaforo_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 4,
    parameter int unsigned COOLDOWN   = 2,
    parameter int unsigned TIMEOUT    = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bt_raw,
    input  logic [2:0] a_state,
    output logic       bt,
    output logic       req_pending,
    output logic [7:0] press_cnt,
    output logic       err_state
);

    localparam logic [7:0] COOLDOWN_INIT = 8'(COOLDOWN);
    localparam logic [7:0] TO_LAST       = 8'(TIMEOUT - 1);
    localparam bit         RETRY_EN      = (TIMEOUT != 0);

    logic       press_evt;
    logic       deb_level_unused;   // FSM reacts to edges only
    logic       a_onehot;
    logic       served;
    logic       retry_due;

    req_state_e state_q;
    logic [7:0] to_cnt_q;
    logic [7:0] cd_cnt_q;
    logic [2:0] a_prev_q;
    logic       bt_q;
    logic       req_pending_q;
    logic [7:0] press_cnt_q;
    logic       err_q;

    debounce_sync #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_debounce (
        .clk   (clk),
        .rst   (rst),
        .din   (bt_raw),
        .level (deb_level_unused),
        .rise  (press_evt)
    );

    // Service is light A going green -> yellow. The history register only
    // ever holds legal one-hot values, so a corrupt sample cannot fake it.
    assign a_onehot  = is_onehot3(a_state);
    assign served    = a_onehot && (a_prev_q == VERDE) && (a_state == AMARELO);
    assign retry_due = RETRY_EN && (to_cnt_q == TO_LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            to_cnt_q      <= 8'd0;
            cd_cnt_q      <= 8'd0;
            a_prev_q      <= VERMELHO;
            bt_q          <= 1'b0;
            req_pending_q <= 1'b0;
            press_cnt_q   <= 8'd0;
            err_q         <= 1'b0;
        end else begin
            bt_q  <= 1'b0;
            err_q <= ~a_onehot;
            if (a_onehot) begin
                a_prev_q <= a_state;
            end

            case (state_q)
                ST_IDLE: begin
                    if (press_evt) begin
                        state_q       <= ST_PENDING;
                        bt_q          <= 1'b1;
                        req_pending_q <= 1'b1;
                        press_cnt_q   <= sat_inc8(press_cnt_q);
                        to_cnt_q      <= 8'd0;
                    end
                end

                ST_PENDING: begin
                    // served takes priority over a coinciding retry
                    if (served) begin
                        state_q       <= ST_COOLDOWN;
                        req_pending_q <= 1'b0;
                        cd_cnt_q      <= COOLDOWN_INIT;
                    end else if (retry_due) begin
                        // With TIMEOUT=1 the retry could land right after the
                        // initial pulse; hold the count one cycle so bt never
                        // stays high across two cycles.
                        if (!bt_q) begin
                            bt_q     <= 1'b1;
                            to_cnt_q <= 8'd0;
                        end
                    end else begin
                        to_cnt_q <= to_cnt_q + 8'd1;
                    end
                end

                ST_COOLDOWN: begin
                    // Lasts COOLDOWN+1 cycles; presses are dropped, including
                    // one arriving on the exit cycle.
                    if (cd_cnt_q == 8'd0) begin
                        state_q <= ST_IDLE;
                    end else begin
                        cd_cnt_q <= cd_cnt_q - 8'd1;
                    end
                end

                default: begin
                    state_q       <= ST_IDLE;
                    req_pending_q <= 1'b0;
                end
            endcase
        end
    end

    assign bt          = bt_q;
    assign req_pending = req_pending_q;
    assign press_cnt   = press_cnt_q;
    assign err_state   = err_q;

endmodule

// File: tb/tb_pedestrian_request_ctrl.sv
// Directed bench for pedestrian_request_ctrl with DEB_CYCLES=4, COOLDOWN=2, TIMEOUT=8.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
module tb_pedestrian_request_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       bt_raw = 1'b0;
    logic [2:0] a_state = 3'b001;
    logic       bt;
    logic       req_pending;
    logic [7:0] press_cnt;
    logic       err_state;

    int checks    = 0;
    int passed    = 0;
    int cyc       = 0;
    int bt_seen   = 0;
    int bt_consec = 0;
    logic bt_last = 1'b0;
    int b;

    pedestrian_request_ctrl #(
        .DEB_CYCLES (4),
        .COOLDOWN   (2),
        .TIMEOUT    (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bt_raw      (bt_raw),
        .a_state     (a_state),
        .bt          (bt),
        .req_pending (req_pending),
        .press_cnt   (press_cnt),
        .err_state   (err_state)
    );

    always #5 clk = ~clk;

    // One rising edge; afterwards cyc is the index of that edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (bt === 1'b1) begin
            bt_seen++;
            if (bt_last) bt_consec++;
        end
        bt_last = (bt === 1'b1);
    endtask

    task automatic run_to(input int t);
        while (cyc < t) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Clean press of 5 cycles, then wait (bounded) for the bt pulse.
    task automatic press_and_wait();
        int w;
        bt_raw = 1'b1;
        repeat (5) tick();
        bt_raw = 1'b0;
        w = 0;
        while (bt !== 1'b1 && w < 12) begin
            tick();
            w++;
        end
    endtask

    initial begin
        int dur [10] = '{3, 1, 2, 3, 1, 2, 3, 1, 2, 2};
        int exp_cnt;

        // Reset held two edges with the button pressed
        rst = 1'b0; bt_raw = 1'b1; a_state = 3'b001;
        tick(); tick();
        chk("rst_bt", bt, 0);
        chk("rst_req_pending", req_pending, 0);
        chk("rst_press_cnt", press_cnt, 0);
        chk("rst_err_state", err_state, 0);
        rst = 1'b1; bt_raw = 1'b0;
        b = cyc; bt_seen = 0;
        run_to(b + 12);
        chk("no_bt_after_rst", bt_seen, 0);

        // Clean press: high sampled from edge b+1, bt after edge b+8
        b = cyc; bt_raw = 1'b1; bt_seen = 0;
        run_to(b + 7);  chk("press_latency_early", bt_seen, 0);
        run_to(b + 8);  chk("press_bt", bt, 1);
                        chk("press_req_pending", req_pending, 1);
                        chk("press_cnt_1", press_cnt, 1);
        run_to(b + 9);  chk("press_bt_width", bt, 0);
        run_to(b + 10); bt_raw = 1'b0;

        // Retries every 8 cycles; a second press lands at b+23 while pending
        run_to(b + 15); bt_raw = 1'b1;
        run_to(b + 16); chk("retry_1", bt, 1);
                        chk("retry_no_count", press_cnt, 1);
        run_to(b + 19); bt_raw = 1'b0;
        run_to(b + 23); chk("pend_press_no_bt", bt, 0);
                        chk("pend_press_no_count", press_cnt, 1);
                        chk("pend_still_pending", req_pending, 1);
        run_to(b + 24); chk("retry_2", bt, 1);

        // Third press lands at b+33, one cycle after service at b+32
        run_to(b + 25); bt_raw = 1'b1;
        run_to(b + 29); bt_raw = 1'b0;
        run_to(b + 30); a_state = 3'b100;
        run_to(b + 31); chk("pre_serve_bt", bt, 0);
                        chk("pre_serve_pending", req_pending, 1);
                        a_state = 3'b010;
        run_to(b + 32); chk("served_on_retry_no_bt", bt, 0);
                        chk("served_clears_pending", req_pending, 0);
                        a_state = 3'b001;
        run_to(b + 33); chk("cooldown_press_no_bt", bt, 0);
                        chk("cooldown_press_no_count", press_cnt, 1);

        // Cooldown ends after b+35; a press reaching the FSM at b+42 is accepted
        run_to(b + 34); bt_raw = 1'b1;
        run_to(b + 38); bt_raw = 1'b0;
        run_to(b + 41); chk("post_cd_early", bt, 0);
        run_to(b + 42); chk("post_cd_bt", bt, 1);
                        chk("post_cd_cnt", press_cnt, 2);
                        chk("post_cd_pending", req_pending, 1);

        // Non-one-hot a_state: flagged, not stored as history
        run_to(b + 43); a_state = 3'b110;
        run_to(b + 44); chk("err_flag", err_state, 1);
                        chk("err_no_service", req_pending, 1);
                        a_state = 3'b100;
        run_to(b + 45); chk("err_one_cycle", err_state, 0);
                        a_state = 3'b110;
        run_to(b + 46); chk("err_flag_2", err_state, 1);
                        chk("err_no_service_2", req_pending, 1);
                        a_state = 3'b010;
        run_to(b + 47); chk("served_across_bad", req_pending, 0);
                        chk("err_clear", err_state, 0);
                        a_state = 3'b001;

        // Bounce: runs of 1-3 cycles never satisfy the 4-cycle debounce
        run_to(b + 52);
        bt_seen = 0;
        for (int i = 0; i < 10; i++) begin
            bt_raw = (i % 2 == 0);
            repeat (dur[i]) tick();
        end
        bt_raw = 1'b0;
        repeat (20) tick();
        chk("bounce_no_bt", bt_seen, 0);
        chk("bounce_cnt", press_cnt, 2);

        // 300 serviced presses: counter saturates at 255
        for (int i = 0; i < 300; i++) begin
            press_and_wait();
            chk("sat_bt", bt, 1);
            exp_cnt = (i + 3 > 255) ? 255 : i + 3;
            chk("sat_cnt", press_cnt, exp_cnt);
            a_state = 3'b100; tick();
            a_state = 3'b010; tick();
            a_state = 3'b001;
            repeat (10) tick();
        end
        chk("sat_final", press_cnt, 255);

        // Reset while pending drops the request
        press_and_wait();
        chk("rst_pend_setup", req_pending, 1);
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("rst_pend_cleared", req_pending, 0);
        chk("rst_pend_cnt", press_cnt, 0);
        chk("rst_pend_bt", bt, 0);
        bt_seen = 0;
        repeat (20) tick();
        chk("rst_pend_no_retry", bt_seen, 0);
        press_and_wait();
        chk("rst_idle_accepts", bt, 1);
        chk("rst_idle_cnt", press_cnt, 1);

        chk("bt_never_consecutive", bt_consec, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
